wg_dispatcher: RTL and testbench

WG_DISPATCHER -- requirements
Module: wg_dispatcher

---
 rtl/wg_dispatcher_if.sv | 25 ++
 rtl/wg_dispatcher.sv | 160 ++++++++++++++++
 tb/tb_wg_dispatcher.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wg_dispatcher_if.sv
// Dispatcher-to-compute-unit handshake bundle: per-CU request/ID offer,
// accept, and work-group completion.
interface wg_dispatcher_if #(
  parameter int unsigned NUM_CU = 4,
  parameter int unsigned WG_W   = 16
);
  logic [NUM_CU-1:0]           cu_req_o;
  logic [NUM_CU-1:0]           cu_ack_i;
  logic [NUM_CU-1:0][WG_W-1:0] cu_wg_id_o;
  logic [NUM_CU-1:0]           cu_done_i;

  modport master (
    output cu_req_o,
    output cu_wg_id_o,
    input  cu_ack_i,
    input  cu_done_i
  );

  modport slave (
    input  cu_req_o,
    input  cu_wg_id_o,
    output cu_ack_i,
    output cu_done_i
  );
endinterface

// File: rtl/wg_dispatcher.sv
// Work-group dispatcher: hands out sequential work-group IDs to free compute
// units round-robin, one outstanding request at a time, and signals kernel done.
module wg_dispatcher #(
  parameter int unsigned NUM_CU = 4,
  parameter int unsigned WG_W   = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [WG_W-1:0] num_wg_i,
  output logic            busy_o,
  output logic            done_o,
  wg_dispatcher_if.master cu_if
);

  localparam int unsigned PTR_W = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;

  localparam logic [1:0] CU_FREE = 2'd0;
  localparam logic [1:0] CU_PEND = 2'd1;
  localparam logic [1:0] CU_RUN  = 2'd2;

  localparam logic [WG_W-1:0] ONE = {{(WG_W-1){1'b0}}, 1'b1};

  logic [1:0]                  state_q, state_d;
  logic [NUM_CU-1:0][1:0]      cu_st_q, cu_st_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [WG_W-1:0]             num_wg_q, num_wg_d;
  logic [WG_W-1:0]             issued_q, issued_d;
  logic [WG_W-1:0]             completed_q, completed_d;
  logic [NUM_CU-1:0]           req_q, req_d;
  logic [NUM_CU-1:0][WG_W-1:0] wg_id_q, wg_id_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic                        sel_vld;
  logic [PTR_W-1:0]            sel_idx;
  logic [PTR_W-1:0]            cand_idx;
  int unsigned                 cand;
  logic                        issue_en;

  // First FREE CU scanning upward from the round-robin pointer, with wrap.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_CU; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_CU;
      cand_idx = PTR_W'(cand);
      if (!sel_vld && (cu_st_q[cand_idx] == CU_FREE)) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cu_st_d     = cu_st_q;
    ptr_d       = ptr_q;
    num_wg_d    = num_wg_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    req_d       = req_q;
    wg_id_d     = wg_id_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_en    = 1'b0;

    if (done_q) busy_d = 1'b0;

    // Completions only count for RUNNING CUs; stray pulses are dropped.
    for (int unsigned i = 0; i < NUM_CU; i++) begin
      if (cu_if.cu_done_i[i] && (cu_st_q[i] == CU_RUN)) begin
        cu_st_d[i]  = CU_FREE;
        completed_d = completed_d + ONE;
      end
    end

    for (int unsigned i = 0; i < NUM_CU; i++) begin
      if (req_q[i] && cu_if.cu_ack_i[i]) begin
        req_d[i]   = 1'b0;
        cu_st_d[i] = CU_RUN;
        issued_d   = issued_q + ONE;
        ptr_d      = PTR_W'((i + 1) % NUM_CU);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_wg_d    = num_wg_i;
          issued_d    = '0;
          completed_d = '0;
          busy_d      = 1'b1;
          if (num_wg_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_DISPATCH;
            issue_en = 1'b1;
          end
        end
      end
      S_DISPATCH: begin
        issue_en = (req_q == '0);
        if (issued_d == num_wg_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (completed_d == num_wg_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // No ack can land while issuing, so issued_d is the next ID to hand out.
    if (issue_en && sel_vld) begin
      req_d[sel_idx]   = 1'b1;
      wg_id_d[sel_idx] = issued_d;
      cu_st_d[sel_idx] = CU_PEND;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cu_st_q     <= '0;
      ptr_q       <= '0;
      num_wg_q    <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      req_q       <= '0;
      wg_id_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cu_st_q     <= cu_st_d;
      ptr_q       <= ptr_d;
      num_wg_q    <= num_wg_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      req_q       <= req_d;
      wg_id_q     <= wg_id_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cu_if.cu_req_o   = req_q;
  assign cu_if.cu_wg_id_o = wg_id_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_wg_dispatcher.sv
// Directed bench for wg_dispatcher with NUM_CU=4, WG_W=16.
module tb_wg_dispatcher;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_wg;
  logic        busy;
  logic        done;

  wg_dispatcher_if #(.NUM_CU(4), .WG_W(16)) cu_bus ();

  wg_dispatcher #(.NUM_CU(4), .WG_W(16)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .num_wg_i (num_wg),
    .busy_o   (busy),
    .done_o   (done),
    .cu_if    (cu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  int unsigned g_n;
  int unsigned g_cu [16];
  int unsigned g_id [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    start            = 1'b0;
    num_wg           = '0;
    cu_bus.cu_ack_i  = '0;
    cu_bus.cu_done_i = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Acks every request in the cycle it appears; each CU completes dly cycles later.
  task automatic run_kernel(input logic [15:0] n, input int unsigned dly,
                            output int unsigned done_cyc);
    int unsigned cd [4];
    logic        onehot_ok;
    logic [3:0]  ack;
    logic [3:0]  dn;
    done_cyc  = 0;
    g_n       = 0;
    onehot_ok = 1'b1;
    foreach (cd[i]) cd[i] = 0;
    start  = 1'b1;
    num_wg = n;
    step();
    start = 1'b0;
    for (int unsigned cyc = 1; cyc <= 100 && done_cyc == 0; cyc++) begin
      if ($countones(cu_bus.cu_req_o) > 1) onehot_ok = 1'b0;
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", {63'd0, busy}, 64'd1);
      end
      ack = '0;
      dn  = '0;
      for (int i = 0; i < 4; i++) begin
        if (cd[i] != 0) begin
          cd[i]--;
          if (cd[i] == 0) dn[i] = 1'b1;
        end
        if (cu_bus.cu_req_o[i]) begin
          ack[i] = 1'b1;
          cd[i]  = dly;
          if (g_n < 16) begin
            g_cu[g_n] = i;
            g_id[g_n] = cu_bus.cu_wg_id_o[i];
            g_n++;
          end
        end
      end
      cu_bus.cu_ack_i  = ack;
      cu_bus.cu_done_i = dn;
      step();
    end
    cu_bus.cu_ack_i  = '0;
    cu_bus.cu_done_i = '0;
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("req_one_hot", {63'd0, onehot_ok}, 64'd1);
  endtask

  int unsigned dc;
  int unsigned exp_cu [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    // Reset values
    do_reset();
    chk("rst_req", {60'd0, cu_bus.cu_req_o}, 64'd0);
    chk("rst_ids", {cu_bus.cu_wg_id_o}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);

    // Zero-size kernel: one-cycle done/busy, no request
    start  = 1'b1;
    num_wg = 16'd0;
    step();
    start = 1'b0;
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_busy", {63'd0, busy}, 64'd1);
    chk("zero_req", {60'd0, cu_bus.cu_req_o}, 64'd0);
    step();
    chk("zero_done_end", {63'd0, done}, 64'd0);
    chk("zero_busy_end", {63'd0, busy}, 64'd0);
    chk("zero_req_end", {60'd0, cu_bus.cu_req_o}, 64'd0);

    // Six work-groups over four CUs, immediate ack, done 5 cycles after ack
    run_kernel(16'd6, 5, dc);
    chk("k6_done_cycle", 64'(dc), 64'd17);
    chk("k6_grants", 64'(g_n), 64'd6);
    for (int unsigned k = 0; k < 6; k++) begin
      chk($sformatf("k6_cu%0d", k), 64'(g_cu[k]), 64'(exp_cu[k]));
      chk($sformatf("k6_id%0d", k), 64'(g_id[k]), 64'(k));
    end

    // Delayed ack on CU0, ignored start and stray done on FREE CU2
    do_reset();
    start  = 1'b1;
    num_wg = 16'd2;
    step();
    chk("dly_c1_req", {60'd0, cu_bus.cu_req_o}, 64'h1);
    chk("dly_c1_id", {48'd0, cu_bus.cu_wg_id_o[0]}, 64'd0);
    num_wg           = 16'd9;
    cu_bus.cu_done_i = 4'b0100;
    step();
    start            = 1'b0;
    cu_bus.cu_done_i = '0;
    chk("dly_c2_req", {60'd0, cu_bus.cu_req_o}, 64'h1);
    chk("dly_c2_id", {48'd0, cu_bus.cu_wg_id_o[0]}, 64'd0);
    chk("dly_c2_busy", {63'd0, busy}, 64'd1);
    step();
    chk("dly_c3_req", {60'd0, cu_bus.cu_req_o}, 64'h1);
    chk("dly_c3_id", {48'd0, cu_bus.cu_wg_id_o[0]}, 64'd0);
    cu_bus.cu_ack_i = 4'b0001;
    step();
    cu_bus.cu_ack_i = '0;
    chk("dly_c4_req", {60'd0, cu_bus.cu_req_o}, 64'h0);
    step();
    chk("dly_c5_req", {60'd0, cu_bus.cu_req_o}, 64'h2);
    chk("dly_c5_id1", {48'd0, cu_bus.cu_wg_id_o[1]}, 64'd1);
    chk("dly_c5_id0_hold", {48'd0, cu_bus.cu_wg_id_o[0]}, 64'd0);
    chk("dly_c5_id2", {48'd0, cu_bus.cu_wg_id_o[2]}, 64'd0);
    cu_bus.cu_ack_i  = 4'b0010;
    cu_bus.cu_done_i = 4'b0001;
    step();
    cu_bus.cu_ack_i  = '0;
    cu_bus.cu_done_i = '0;
    chk("dly_c6_req", {60'd0, cu_bus.cu_req_o}, 64'h0);
    step();
    chk("dly_c7_done", {63'd0, done}, 64'd0);
    cu_bus.cu_done_i = 4'b0010;
    step();
    cu_bus.cu_done_i = '0;
    chk("dly_c8_done", {63'd0, done}, 64'd1);
    chk("dly_c8_busy", {63'd0, busy}, 64'd1);
    step();
    chk("dly_c9_done", {63'd0, done}, 64'd0);
    chk("dly_c9_busy", {63'd0, busy}, 64'd0);

    // Pointer wrap: last grant to CU3, next kernel starts at CU0
    do_reset();
    run_kernel(16'd4, 5, dc);
    chk("wrap_done_cycle", 64'(dc), 64'd13);
    chk("wrap_last_cu", 64'(g_cu[3]), 64'd3);
    start  = 1'b1;
    num_wg = 16'd1;
    step();
    start = 1'b0;
    chk("wrap_req", {60'd0, cu_bus.cu_req_o}, 64'h1);
    chk("wrap_id", {48'd0, cu_bus.cu_wg_id_o[0]}, 64'd0);
    cu_bus.cu_ack_i = 4'b0001;
    step();
    cu_bus.cu_ack_i  = '0;
    cu_bus.cu_done_i = 4'b0001;
    step();
    cu_bus.cu_done_i = '0;
    chk("wrap_k1_done", {63'd0, done}, 64'd1);

    // Reset mid-kernel with CU0 and CU1 running
    do_reset();
    start  = 1'b1;
    num_wg = 16'd4;
    step();
    start = 1'b0;
    cu_bus.cu_ack_i = 4'b0001;
    step();
    cu_bus.cu_ack_i = '0;
    step();
    chk("mid_req1", {60'd0, cu_bus.cu_req_o}, 64'h2);
    cu_bus.cu_ack_i = 4'b0010;
    step();
    cu_bus.cu_ack_i = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req", {60'd0, cu_bus.cu_req_o}, 64'd0);
    chk("mid_rst_ids", {cu_bus.cu_wg_id_o}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    cu_bus.cu_done_i = 4'b0011;
    step();
    cu_bus.cu_done_i = '0;
    begin
      logic any_done;
      any_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (done || busy || (cu_bus.cu_req_o != '0)) any_done = 1'b1;
        step();
      end
      chk("mid_late_done_ignored", {63'd0, any_done}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
